// File: rtl/wave_capture.sv
// Captures one screen of audio samples, starting at a rising zero crossing, into the
// half of a double-buffered waveform RAM the display is not reading; flips halves when the display is idle.
module wave_capture #(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  new_sample_ready,
   input  logic [15:0]           new_sample_in,
   input  logic                  wave_display_idle,
   output logic [DEPTH_LOG2:0]   write_address,
   output logic                  write_enable,
   output logic [7:0]            write_sample,
   output logic                  read_index
);

   typedef enum logic [1:0] {
      S_ARMED,
      S_ACTIVE,
      S_WAIT
   } state_t;

   state_t                state_q;
   logic [DEPTH_LOG2-1:0] count_q;
   logic                  read_index_q;
   logic                  prev_neg_q;
   logic                  write_enable_q;
   logic [DEPTH_LOG2:0]   write_address_q;
   logic [7:0]            write_sample_q;

   logic [7:0]            sample_d;
   logic                  crossing;
   logic                  last_write;

   // Top byte with the sign bit inverted maps signed audio onto 0x00..0xFF.
   assign sample_d   = {~new_sample_in[15], new_sample_in[14:8]};
   assign crossing   = new_sample_ready & prev_neg_q & ~new_sample_in[15];
   assign last_write = (count_q == {DEPTH_LOG2{1'b1}});

   // NOTE: every register in this block uses <= so all of them update from the
   // same pre-edge values; a blocking = here would let later lines see new state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= S_ARMED;
         count_q         <= '0;
         read_index_q    <= 1'b0;
         prev_neg_q      <= 1'b0;
         write_enable_q  <= 1'b0;
         write_address_q <= '0;
         write_sample_q  <= '0;
      end else begin
         write_enable_q <= 1'b0;
         if (new_sample_ready) begin
            prev_neg_q <= new_sample_in[15];
         end

         case (state_q)
            S_ARMED: begin
               if (crossing) begin
                  write_enable_q  <= 1'b1;
                  write_address_q <= {~read_index_q, {DEPTH_LOG2{1'b0}}};
                  write_sample_q  <= sample_d;
                  count_q         <= {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                  state_q         <= S_ACTIVE;
               end
            end

            S_ACTIVE: begin
               if (new_sample_ready) begin
                  write_enable_q  <= 1'b1;
                  write_address_q <= {~read_index_q, count_q};
                  write_sample_q  <= sample_d;
                  count_q         <= count_q + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
                  if (last_write) begin
                     state_q <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               // The flip waits for idle so the display never sees a half-drawn buffer.
               if (wave_display_idle) begin
                  read_index_q <= ~read_index_q;
                  state_q      <= S_ARMED;
               end
            end

            default: state_q <= S_ARMED;
         endcase
      end
   end

   assign write_address = write_address_q;
   assign write_enable  = write_enable_q;
   assign write_sample  = write_sample_q;
   assign read_index    = read_index_q;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed scenarios plus a randomized run
// checked against a capture-level reference model.
module tb_wave_capture;

   localparam int D    = 8;
   localparam int N    = 1 << D;
   localparam int NCYC = 2500;

   logic          clk;
   logic          reset;
   logic          new_sample_ready;
   logic [15:0]   new_sample_in;
   logic          wave_display_idle;
   logic [D:0]    write_address;
   logic          write_enable;
   logic [7:0]    write_sample;
   logic          read_index;

   int n_cmp = 0;
   int n_err = 0;

   wave_capture #(.DEPTH_LOG2(D)) dut (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (new_sample_ready),
      .new_sample_in     (new_sample_in),
      .wave_display_idle (wave_display_idle),
      .write_address     (write_address),
      .write_enable      (write_enable),
      .write_sample      (write_sample),
      .read_index        (read_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Signed sample shifted into 0..65535, top byte kept.
   function automatic logic [7:0] to_unsigned(input logic [15:0] v);
      int s;
      s = $signed(v);
      return 8'((s + 32768) / 256);
   endfunction

   task automatic step(input logic rdy, input logic [15:0] val, input logic idle);
      new_sample_ready  = rdy;
      new_sample_in     = val;
      wave_display_idle = idle;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_write(input string name, input int addr, input logic [7:0] data);
      n_cmp++;
      if (write_enable !== 1'b1 || int'(write_address) !== addr || write_sample !== data) begin
         n_err++;
         $display("FAIL %s: got we=%b addr=%h data=%h, want we=1 addr=%h data=%h",
                  name, write_enable, write_address, write_sample, addr, data);
      end
   endtask

   task automatic expect_idle_bus(input string name, input logic ri);
      n_cmp++;
      if (write_enable !== 1'b0 || read_index !== ri) begin
         n_err++;
         $display("FAIL %s: got we=%b read_index=%b, want we=0 read_index=%b",
                  name, write_enable, read_index, ri);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      new_sample_ready = 1'b0;
      new_sample_in = '0;
      wave_display_idle = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if ({write_enable, write_address, write_sample, read_index} !== '0) begin
         n_err++;
         $display("FAIL reset_values: got we=%b addr=%h data=%h ri=%b, want all 0",
                  write_enable, write_address, write_sample, read_index);
      end
      reset = 1'b0;
      step(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic test_arming();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'h0200, 1'b0);
         expect_idle_bus("positive_only_no_trigger", 1'b0);
      end
      step(1'b1, 16'hFF00, 1'b0);
      expect_idle_bus("negative_no_write", 1'b0);
      step(1'b1, 16'h0200, 1'b0);
      expect_write("first_capture_write", 'h100, 8'h82);
   endtask

   task automatic test_full_capture();
      logic [15:0] v;
      for (int k = 1; k < N; k++) begin
         v = (k == N - 1) ? 16'h7FFF : 16'(16'h8000 + (k - 1) * 256);
         step(1'b1, v, 1'b0);
         expect_write("capture_ramp", 'h100 + k, to_unsigned(v));
         if (k == 1) begin
            n_cmp++;
            if (write_sample !== 8'h00) begin
               n_err++;
               $display("FAIL extreme_min: got %h want 00", write_sample);
            end
         end
         if (k == N - 1) begin
            n_cmp++;
            if (write_sample !== 8'hFF) begin
               n_err++;
               $display("FAIL extreme_max: got %h want ff", write_sample);
            end
         end
      end
   endtask

   task automatic test_wait();
      logic [15:0] v;
      for (int i = 0; i < 20; i++) begin
         v = (i % 2 == 0) ? 16'hC000 : 16'h1234;
         step(1'b1, v, 1'b0);
         expect_idle_bus("wait_no_write", 1'b0);
         n_cmp++;
         if (write_address !== 9'h1FF || write_sample !== 8'hFF) begin
            n_err++;
            $display("FAIL wait_hold: got addr=%h data=%h want addr=1ff data=ff",
                     write_address, write_sample);
         end
      end
      step(1'b0, 16'h0000, 1'b1);
      expect_idle_bus("flip_on_idle", 1'b1);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b1, 16'h8001, 1'b0);
      expect_idle_bus("armed_negative", 1'b1);
      step(1'b1, 16'h0000, 1'b0);
      expect_write("low_half_start", 'h000, 8'h80);
      for (int k = 1; k < N; k++) begin
         v = 16'($urandom);
         step(1'b1, v, 1'b0);
         expect_write("low_half_capture", k, to_unsigned(v));
      end
      step(1'b1, 16'h0100, 1'b0);
      expect_idle_bus("low_half_done", 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      expect_idle_bus("flip_back", 1'b0);
      step(1'b0, 16'h0000, 1'b0);
   endtask

   task automatic test_reset_mid_capture();
      step(1'b1, 16'hFF00, 1'b0);
      step(1'b1, 16'h0100, 1'b0);
      expect_write("mid_first", 'h100, 8'h81);
      for (int k = 1; k < 100; k++) begin
         step(1'b1, 16'(k * 64), 1'b0);
         expect_write("mid_capture", 'h100 + k, to_unsigned(16'(k * 64)));
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({write_enable, write_address, write_sample, read_index} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got we=%b addr=%h data=%h ri=%b, want all 0",
                  write_enable, write_address, write_sample, read_index);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(1'b1, 16'h0100, 1'b0);
      expect_idle_bus("post_reset_no_trigger", 1'b0);
      n_cmp++;
      if (write_address !== '0 || write_sample !== 8'h00) begin
         n_err++;
         $display("FAIL post_reset_hold: got addr=%h data=%h want 0/0",
                  write_address, write_sample);
      end
   endtask

   task automatic test_idle_active();
      logic [15:0] v;
      step(1'b1, 16'hFF00, 1'b1);
      step(1'b1, 16'h0300, 1'b1);
      expect_write("restart_at_base", 'h100, 8'h83);
      for (int k = 1; k < N; k++) begin
         v = 16'($urandom);
         step(1'b1, v, 1'b1);
         expect_write("idle_active_capture", 'h100 + k, to_unsigned(v));
         n_cmp++;
         if (read_index !== 1'b0) begin
            n_err++;
            $display("FAIL idle_active_early_flip: k=%0d got ri=%b want 0", k, read_index);
         end
      end
      step(1'b0, 16'h0000, 1'b1);
      expect_idle_bus("idle_active_flip", 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 16'h0000, 1'b1);
         expect_idle_bus("idle_active_single_flip", 1'b1);
      end
   endtask

   logic       r_rdy [NCYC];
   logic [15:0] r_smp [NCYC];
   logic       r_idl [NCYC];
   logic       o_we  [NCYC];
   int         o_addr[NCYC];
   logic [7:0] o_dat [NCYC];
   logic       o_ri  [NCYC];
   logic       x_we  [NCYC];
   int         x_addr[NCYC];
   logic [7:0] x_dat [NCYC];
   logic       x_ri  [NCYC];
   logic       prev_sign[NCYC];

   task automatic test_random();
      logic last;
      logic ri;
      int   e, c0, cl, f, k, shown;

      reset = 1'b1;
      step(1'b0, 16'h0000, 1'b0);
      reset = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         r_rdy[c] = ($urandom_range(9) < 7);
         r_smp[c] = 16'($urandom);
         r_idl[c] = ($urandom_range(9) < 2);
         step(r_rdy[c], r_smp[c], r_idl[c]);
         o_we[c]   = write_enable;
         o_addr[c] = int'(write_address);
         o_dat[c]  = write_sample;
         o_ri[c]   = read_index;
      end
      step(1'b0, 16'h0000, 1'b0);

      // Capture-level model: find a crossing, take the next N strobes, then
      // flip at the first idle cycle after the last of them.
      last = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
         prev_sign[c] = last;
         if (r_rdy[c]) last = r_smp[c][15];
         x_we[c] = 1'b0; x_addr[c] = 0; x_dat[c] = 8'h00; x_ri[c] = 1'b0;
      end
      ri = 1'b0;
      e  = 0;
      while (e < NCYC) begin
         c0 = -1;
         for (int c = e; c < NCYC; c++) begin
            if (r_rdy[c] && prev_sign[c] && !r_smp[c][15]) begin
               c0 = c;
               break;
            end
         end
         if (c0 < 0) break;
         k  = 0;
         cl = c0;
         for (int c = c0; c < NCYC && k < N; c++) begin
            if (r_rdy[c]) begin
               x_we[c]   = 1'b1;
               x_addr[c] = (ri ? 0 : N) + k;
               x_dat[c]  = to_unsigned(r_smp[c]);
               k++;
               cl = c;
            end
         end
         if (k < N) break;
         f = -1;
         for (int c = cl + 1; c < NCYC; c++) begin
            if (r_idl[c]) begin
               f = c;
               break;
            end
         end
         if (f < 0) break;
         ri = ~ri;
         for (int c = f; c < NCYC; c++) x_ri[c] = ri;
         e = f + 1;
      end

      shown = 0;
      for (int c = 0; c < NCYC; c++) begin
         n_cmp++;
         if (o_we[c] !== x_we[c] || o_ri[c] !== x_ri[c] ||
             (x_we[c] && (o_addr[c] != x_addr[c] || o_dat[c] !== x_dat[c]))) begin
            n_err++;
            if (shown < 20) begin
               shown++;
               $display("FAIL random cycle %0d: got we=%b addr=%h data=%h ri=%b, want we=%b addr=%h data=%h ri=%b",
                        c, o_we[c], o_addr[c], o_dat[c], o_ri[c],
                        x_we[c], x_addr[c], x_dat[c], x_ri[c]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_arming();
      test_full_capture();
      test_wait();
      test_reset_mid_capture();
      test_idle_active();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wave_capture.md
# wave_capture

Captures one screen-width of audio samples into the double-buffered waveform sample RAM that the waveform display reads. Each capture is triggered on a rising zero crossing. The block writes 2^DEPTH_LOG2 consecutive samples into the half of the RAM the display is not reading. It then waits for the display to go idle and flips `read_index`, so the display never draws a half-written buffer.

## Interface

Parameters:
- `DEPTH_LOG2`, default 8: log2 of samples per capture; the RAM address is `DEPTH_LOG2+1` bits.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `new_sample_ready`  input  1  one-cycle strobe; `new_sample_in` is valid this cycle. May be high on consecutive cycles.
- `new_sample_in`  input  16  signed two's-complement audio sample.
- `wave_display_idle`  input  1  high while the display is outside its active drawing region.
- `write_address`  output  DEPTH_LOG2+1  RAM write address, `{~read_index, count}`.
- `write_enable`  output  1  one-cycle RAM write strobe.
- `write_sample`  output  8  unsigned sample to write.
- `read_index`  output  1  RAM half the display reads; the block writes the other half.

## Operation

Sample conversion:
- `write_sample = {~new_sample_in[15], new_sample_in[14:8]}`, i.e. the top byte offset to unsigned (0x8000→0x00, 0x0000→0x80, 0x7FFF→0xFF).

Sign history:
- `prev_neg` is a register loaded with `new_sample_in[15]` on every `new_sample_ready`, in every state.
- Reset value of `prev_neg` is 0.

State machine (3 states, reset state ARMED):
- ARMED:
  - On `new_sample_ready` with `prev_neg==1` and `new_sample_in[15]==0` (rising zero crossing): write this sample at `count=0`, set `count=1`, go to ACTIVE.
  - Otherwise stay in ARMED and write nothing.
- ACTIVE:
  - On each `new_sample_ready`, write the sample at `{~read_index, count}` and increment `count`.
  - The write with `count == 2^DEPTH_LOG2-1` is the last write. `count` wraps to 0 and the state goes to WAIT.
- WAIT:
  - `new_sample_ready` produces no write; only `prev_neg` updates.
  - When `wave_display_idle==1`, toggle `read_index` and go to ARMED.
- `wave_display_idle` is ignored in ARMED and ACTIVE.
- A capture never spans two values of `read_index`: `read_index` changes only on the WAIT→ARMED transition.
- Arithmetic: `count` is DEPTH_LOG2 bits unsigned and wraps modulo 2^DEPTH_LOG2.

## Timing

Reset values:
- state=ARMED, `read_index`=0, `count`=0, `prev_neg`=0.
- `write_enable`=0, `write_address`=0, `write_sample`=0x00.

Write latency and registering:
- All outputs are registered.
- A qualifying `new_sample_ready` in cycle N produces `write_enable`=1 in cycle N+1. `write_address` and `write_sample` are valid in that same cycle.
- `write_enable` is high for exactly one cycle per accepted sample.
- `write_address` and `write_sample` hold their last values while `write_enable`=0.

Back-to-back samples:
- `new_sample_ready` high on consecutive cycles produces consecutive writes with consecutive addresses. No sample is dropped in ACTIVE.

Last write and buffer flip:
- The final write of a capture appears one cycle after its strobe. The state is WAIT from that same cycle.
- If `wave_display_idle` is already high on entry to WAIT, `read_index` toggles on the next edge. The earliest toggle is therefore 2 cycles after the final strobe, and always after the final write has been issued.

Reset behaviour:
- Asserting `reset` at any time, including mid-capture or mid-WAIT, forces the reset values immediately (asynchronous).
- After reset deasserts, a new capture requires a fresh negative sample followed by a nonnegative one.

## Test plan

- **Reset:** assert `reset` mid-stream → all outputs are 0 within the same cycle; `read_index`=0; a following 0x0100 strobe produces no write (`prev_neg`=0).
- **Arming:**
  - Strobe 0xFF00, then 0x0200 → one cycle after the second strobe, `write_enable`=1, `write_address`=0x100, `write_sample`=0x82.
  - Strobes of 0x0200 alone never trigger a capture.
- **Full capture:**
  - Stimulus: after arming, 255 further strobes on consecutive cycles, values ramping.
  - Response: 256 writes at addresses 0x100–0x1FF in order, no gaps, then no more writes.
  - Extreme values: 0x8000 writes 0x00 and 0x7FFF writes 0xFF.
- **WAIT behaviour:**
  - Hold `wave_display_idle`=0 while sending 20 strobes including crossings → no writes and `read_index` stays 0.
  - Raise idle → `read_index` becomes 1 on the next edge.
  - The next capture then writes addresses 0x000–0x0FF.
- **Reset mid-capture:**
  - Reset after 100 writes → state is ARMED, `count`=0, `read_index`=0.
  - The next capture restarts at address 0x100.
- **Idle during ACTIVE:** hold `wave_display_idle`=1 throughout a capture → `read_index` toggles only after the 256th write, exactly once.
